hyperbus_trans_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single HyperBus PHY transaction channel between several requesters (the AXI front-end and the uDMA RX/TX channels). It runs in the PHY clock domain, after the clock-domain crossings and before the PHY. It grants one requester at a time and issues that requester's transaction descriptor to the PHY. It holds ownership until the PHY reports completion, then routes the done/error status back to the owner.

---
 rtl/hyperbus_trans_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_hyperbus_trans_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_trans_arbiter.sv
// Round-robin arbiter sharing the HyperBus PHY transaction channel among NumReq requesters.
// Optional watchdog on WAIT_DONE is built when HYPERBUS_ARB_WATCHDOG_EN is defined.
module hyperbus_trans_arbiter #(
    parameter int NumReq        = 2,
    parameter int AddrWidth     = 32,
    parameter int LenWidth      = 16,
    parameter int TimeoutCycles = 1024,
    parameter int OwnerWidth    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                          clk_phy_i,
    input  logic                          rst_phy_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*LenWidth-1:0]    req_len_i,
    input  logic [NumReq-1:0]             req_write_i,
    output logic                          phy_trans_valid_o,
    input  logic                          phy_trans_ready_i,
    output logic [AddrWidth-1:0]          phy_addr_o,
    output logic [LenWidth-1:0]           phy_len_o,
    output logic                          phy_write_o,
    input  logic                          phy_done_i,
    input  logic                          phy_error_i,
    output logic [NumReq-1:0]             done_o,
    output logic [NumReq-1:0]             error_o,
    output logic                          timeout_o,
    output logic                          busy_o,
    output logic [OwnerWidth-1:0]         owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    trans_valid_q, trans_valid_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [LenWidth-1:0]     len_q, len_d;
    logic                    write_q, write_d;
    logic [OwnerWidth-1:0]   owner_q, owner_d;
    logic [OwnerWidth-1:0]   last_owner_q, last_owner_d;
    logic [NumReq-1:0]       done_q, done_d;
    logic [NumReq-1:0]       error_q, error_d;
    logic                    busy_q, busy_d;

`ifdef HYPERBUS_ARB_WATCHDOG_EN
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0]     wd_cnt_q, wd_cnt_d;
    logic                    timeout_q, timeout_d;
`else
    logic                    unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles > 0);
`endif

    // Round-robin search starting one past the last completed owner.
    logic                    win_found;
    logic [OwnerWidth-1:0]   win_idx;
    logic [NumReq-1:0]       win_onehot;
    logic [AddrWidth-1:0]    win_addr;
    logic [LenWidth-1:0]     win_len;
    logic                    win_write;

    always_comb begin
        int                  idx;
        logic [OwnerWidth-1:0] idx_sel;
        win_found  = 1'b0;
        win_idx    = last_owner_q;
        win_onehot = '0;
        win_addr   = '0;
        win_len    = '0;
        win_write  = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            idx     = (int'(last_owner_q) + 1 + k) % NumReq;
            idx_sel = OwnerWidth'(idx);
            if (!win_found && req_valid_i[idx_sel]) begin
                win_found           = 1'b1;
                win_idx             = idx_sel;
                win_onehot[idx_sel] = 1'b1;
                win_addr            = req_addr_i[idx*AddrWidth +: AddrWidth];
                win_len             = req_len_i[idx*LenWidth +: LenWidth];
                win_write           = req_write_i[idx_sel];
            end
        end
    end

    // Handshakes: a descriptor moves when valid and ready are both high in the same
    // cycle; the PHY-side valid stays high with frozen fields until ready is seen.
    assign req_ready_o = (state_q == ST_IDLE) ? win_onehot : '0;

    always_comb begin
        state_d       = state_q;
        trans_valid_d = trans_valid_q;
        addr_d        = addr_q;
        len_d         = len_q;
        write_d       = write_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        done_d        = '0;
        error_d       = '0;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    addr_d        = win_addr;
                    len_d         = win_len;
                    write_d       = win_write;
                    owner_d       = win_idx;
                    trans_valid_d = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (phy_trans_ready_i) begin
                    trans_valid_d = 1'b0;
                    state_d       = ST_WAIT_DONE;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
                    wd_cnt_d      = '0;
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (phy_done_i) begin
                    for (int i = 0; i < NumReq; i++) begin
                        done_d[i]  = (owner_q == OwnerWidth'(i));
                        error_d[i] = (owner_q == OwnerWidth'(i)) && phy_error_i;
                    end
                    last_owner_d = owner_q;
                    state_d      = ST_IDLE;
                end
`ifdef HYPERBUS_ARB_WATCHDOG_EN
                else if (wd_cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                    for (int i = 0; i < NumReq; i++) begin
                        done_d[i]  = (owner_q == OwnerWidth'(i));
                        error_d[i] = (owner_q == OwnerWidth'(i));
                    end
                    timeout_d    = 1'b1;
                    last_owner_d = owner_q;
                    state_d      = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_phy_i) begin
        if (!rst_phy_ni) begin
            state_q       <= ST_IDLE;
            trans_valid_q <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            write_q       <= 1'b0;
            owner_q       <= '0;
            last_owner_q  <= OwnerWidth'(NumReq - 1);
            done_q        <= '0;
            error_q       <= '0;
            busy_q        <= 1'b0;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
            wd_cnt_q      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            trans_valid_q <= trans_valid_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            write_q       <= write_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            done_q        <= done_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign phy_trans_valid_o = trans_valid_q;
    assign phy_addr_o        = addr_q;
    assign phy_len_o         = len_q;
    assign phy_write_o       = write_q;
    assign done_o            = done_q;
    assign error_o           = error_q;
    assign busy_o            = busy_q;
    assign owner_o           = owner_q;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
    assign timeout_o         = timeout_q;
`else
    assign timeout_o         = 1'b0;
`endif

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Directed bench for hyperbus_trans_arbiter with two requesters and a 16-cycle watchdog limit.
module tb_hyperbus_trans_arbiter;

    localparam int NumReq = 2;
    localparam int AW     = 32;
    localparam int LW     = 16;
    localparam int TO     = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NumReq-1:0]     req_valid;
    logic [NumReq-1:0]     req_ready;
    logic [NumReq*AW-1:0]  req_addr;
    logic [NumReq*LW-1:0]  req_len;
    logic [NumReq-1:0]     req_write;
    logic                  phy_valid;
    logic                  phy_ready;
    logic [AW-1:0]         phy_addr;
    logic [LW-1:0]         phy_len;
    logic                  phy_write;
    logic                  phy_done;
    logic                  phy_error;
    logic [NumReq-1:0]     done;
    logic [NumReq-1:0]     error;
    logic                  timeout;
    logic                  busy;
    logic                  owner;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hyperbus_trans_arbiter #(
        .NumReq(NumReq), .AddrWidth(AW), .LenWidth(LW), .TimeoutCycles(TO)
    ) dut (
        .clk_phy_i         (clk),
        .rst_phy_ni        (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_addr_i        (req_addr),
        .req_len_i         (req_len),
        .req_write_i       (req_write),
        .phy_trans_valid_o (phy_valid),
        .phy_trans_ready_i (phy_ready),
        .phy_addr_o        (phy_addr),
        .phy_len_o         (phy_len),
        .phy_write_o       (phy_write),
        .phy_done_i        (phy_done),
        .phy_error_i       (phy_error),
        .done_o            (done),
        .error_o           (error),
        .timeout_o         (timeout),
        .busy_o            (busy),
        .owner_o           (owner)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        req_write = '0;
        phy_ready = 1'b0;
        phy_done  = 1'b0;
        phy_error = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({phy_valid, phy_addr, phy_len, phy_write, done, error, timeout, busy, req_ready} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b addr=%h len=%h wr=%b done=%b err=%b to=%b busy=%b rdy=%b, exp all 0",
                     phy_valid, phy_addr, phy_len, phy_write, done, error, timeout, busy, req_ready);
        end
        n_checks++;
        if (owner !== 1'b0) begin n_errors++; $display("FAIL reset_owner: got %b exp 0", owner); end
    endtask

    task automatic test_single();
        cyc();
        req_valid = 2'b01;
        req_addr  = {32'hFFFF_0000, 32'h0000_0100};
        req_len   = {16'h0055, 16'h0007};
        req_write = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_errors++; $display("FAIL single_grant: got %b exp 01", req_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL single_idle_busy: got %b exp 0", busy); end
        cyc();
        req_valid = 2'b00;
        phy_ready = 1'b1;
        #1;
        n_checks++;
        if ({phy_valid, phy_addr, phy_len, phy_write} !== {1'b1, 32'h0000_0100, 16'h0007, 1'b1}) begin
            n_errors++;
            $display("FAIL single_issue: got v=%b a=%h l=%h w=%b exp 1/00000100/0007/1", phy_valid, phy_addr, phy_len, phy_write);
        end
        n_checks++;
        if ({owner, busy, req_ready} !== {1'b0, 1'b1, 2'b00}) begin
            n_errors++;
            $display("FAIL single_issue_state: got owner=%b busy=%b rdy=%b exp 0/1/00", owner, busy, req_ready);
        end
        cyc();
        phy_ready = 1'b0;
        #1;
        n_checks++;
        if ({phy_valid, busy} !== 2'b01) begin n_errors++; $display("FAIL single_wait: got valid=%b busy=%b exp 0/1", phy_valid, busy); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            n_checks++;
            if (done !== 2'b00) begin n_errors++; $display("FAIL single_early_done: got %b exp 00", done); end
        end
        cyc();
        phy_done  = 1'b1;
        phy_error = 1'b0;
        #1;
        n_checks++;
        if (done !== 2'b00) begin n_errors++; $display("FAIL single_done_same_cycle: got %b exp 00", done); end
        cyc();
        phy_done = 1'b0;
        #1;
        n_checks++;
        if ({done, error, busy} !== {2'b01, 2'b00, 1'b0}) begin
            n_errors++;
            $display("FAIL single_done: got done=%b err=%b busy=%b exp 01/00/0", done, error, busy);
        end
        cyc();
        #1;
        n_checks++;
        if (done !== 2'b00) begin n_errors++; $display("FAIL single_done_pulse: got %b exp 00", done); end
    endtask

    task automatic test_round_robin();
        int         exp_own [4] = '{0, 1, 0, 1};
        logic [1:0] oh;
        logic [AW-1:0] ea;
        logic [LW-1:0] el;
        logic          ew;
        do_reset();
        cyc();
        req_valid = 2'b11;
        req_addr  = {32'h0000_B004, 32'h0000_A000};
        req_len   = {16'd9, 16'd3};
        req_write = 2'b10;
        phy_ready = 1'b1;
        phy_done  = 1'b1;
        phy_error = 1'b0;
        for (int t = 0; t < 4; t++) begin
            oh = (exp_own[t] == 0) ? 2'b01 : 2'b10;
            ea = (exp_own[t] == 0) ? 32'h0000_A000 : 32'h0000_B004;
            el = (exp_own[t] == 0) ? 16'd3 : 16'd9;
            ew = (exp_own[t] == 0) ? 1'b0 : 1'b1;
            #1;
            n_checks++;
            if (req_ready !== oh) begin n_errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", t, req_ready, oh); end
            cyc();
            #1;
            n_checks++;
            if ({owner, phy_valid, phy_addr, phy_len, phy_write} !== {1'(exp_own[t]), 1'b1, ea, el, ew}) begin
                n_errors++;
                $display("FAIL rr_issue[%0d]: got own=%b v=%b a=%h l=%h w=%b exp own=%0d v=1 a=%h l=%h w=%b",
                         t, owner, phy_valid, phy_addr, phy_len, phy_write, exp_own[t], ea, el, ew);
            end
            cyc();
            #1;
            n_checks++;
            if ({phy_valid, done} !== 3'b000) begin n_errors++; $display("FAIL rr_wait[%0d]: got valid=%b done=%b exp 0/00", t, phy_valid, done); end
            cyc();
            if (t == 3) req_valid = 2'b00;
            #1;
            n_checks++;
            if ({done, error} !== {oh, 2'b00}) begin n_errors++; $display("FAIL rr_done[%0d]: got done=%b err=%b exp %b/00", t, done, error, oh); end
        end
        #1;
        n_checks++;
        if (req_ready !== 2'b00) begin n_errors++; $display("FAIL rr_stop: got %b exp 00", req_ready); end
        phy_ready = 1'b0;
        phy_done  = 1'b0;
    endtask

    task automatic test_ready_stall_error();
        cyc();
        req_valid = 2'b10;
        req_addr  = {32'hDEAD_BEE0, 32'h0000_0000};
        req_len   = {16'h1234, 16'h0000};
        req_write = 2'b00;
        phy_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin n_errors++; $display("FAIL stall_lone_regrant: got %b exp 10", req_ready); end
        cyc();
        req_valid = 2'b00;
        phy_done  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++;
            if ({phy_valid, phy_addr, phy_len, phy_write, owner, done} !== {1'b1, 32'hDEAD_BEE0, 16'h1234, 1'b0, 1'b1, 2'b00}) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got v=%b a=%h l=%h w=%b own=%b done=%b exp 1/deadbee0/1234/0/1/00",
                         c, phy_valid, phy_addr, phy_len, phy_write, owner, done);
            end
            cyc();
        end
        phy_done  = 1'b0;
        phy_ready = 1'b1;
        #1;
        n_checks++;
        if (phy_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid_at_ready: got %b exp 1", phy_valid); end
        cyc();
        phy_ready = 1'b0;
        #1;
        n_checks++;
        if ({phy_valid, done} !== 3'b000) begin n_errors++; $display("FAIL stall_wait: got valid=%b done=%b exp 0/00", phy_valid, done); end
        cyc();
        phy_done  = 1'b1;
        phy_error = 1'b1;
        cyc();
        phy_done  = 1'b0;
        phy_error = 1'b0;
        #1;
        n_checks++;
        if ({done, error} !== 4'b1010) begin n_errors++; $display("FAIL error_done: got done=%b err=%b exp 10/10", done, error); end
        cyc();
        #1;
        n_checks++;
        if ({done, error} !== 4'b0000) begin n_errors++; $display("FAIL error_pulse: got done=%b err=%b exp 00/00", done, error); end
    endtask

    task automatic test_mid_reset();
        cyc();
        req_valid = 2'b01;
        req_addr  = {32'h55AA_0000, 32'h0000_0040};
        req_len   = {16'hFFFF, 16'h0000};
        req_write = 2'b10;
        phy_ready = 1'b1;
        phy_done  = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_errors++; $display("FAIL mr_grant0: got %b exp 01", req_ready); end
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
        phy_ready = 1'b0;
        phy_done  = 1'b0;
        req_valid = 2'b10;
        #1;
        n_checks++;
        if ({done, req_ready} !== 4'b0110) begin n_errors++; $display("FAIL mr_done0_grant1: got done=%b rdy=%b exp 01/10", done, req_ready); end
        cyc();
        req_valid = 2'b00;
        phy_ready = 1'b1;
        #1;
        n_checks++;
        if ({owner, phy_valid, phy_len} !== {1'b1, 1'b1, 16'hFFFF}) begin
            n_errors++;
            $display("FAIL mr_issue1: got own=%b v=%b l=%h exp 1/1/ffff", owner, phy_valid, phy_len);
        end
        cyc();
        phy_ready = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL mr_wait_busy: got %b exp 1", busy); end
        rst_n = 1'b0;
        cyc();
        rst_n    = 1'b1;
        phy_done = 1'b1;
        #1;
        n_checks++;
        if ({phy_valid, phy_addr, phy_len, phy_write, done, error, timeout, busy, owner} !== '0) begin
            n_errors++;
            $display("FAIL mr_reset_outputs: got v=%b a=%h l=%h w=%b done=%b err=%b to=%b busy=%b own=%b exp all 0",
                     phy_valid, phy_addr, phy_len, phy_write, done, error, timeout, busy, owner);
        end
        cyc();
        phy_done  = 1'b0;
        req_valid = 2'b11;
        #1;
        n_checks++;
        if ({done, busy, req_ready} !== 5'b00001) begin
            n_errors++;
            $display("FAIL mr_after_reset: got done=%b busy=%b rdy=%b exp 00/0/01", done, busy, req_ready);
        end
        cyc();
        req_valid = 2'b00;
        phy_ready = 1'b1;
        #1;
        n_checks++;
        if ({owner, phy_addr} !== {1'b0, 32'h0000_0040}) begin
            n_errors++;
            $display("FAIL mr_issue0: got own=%b a=%h exp 0/00000040", owner, phy_addr);
        end
        cyc();
        phy_ready = 1'b0;
        phy_done  = 1'b1;
        cyc();
        phy_done = 1'b0;
        #1;
        n_checks++;
        if (done !== 2'b01) begin n_errors++; $display("FAIL mr_final_done: got %b exp 01", done); end
    endtask

    task automatic test_watchdog();
        cyc();
        req_valid = 2'b10;
        req_addr  = {32'h0000_0200, 32'h0000_0000};
        req_len   = {16'h000F, 16'h0000};
        req_write = 2'b10;
        phy_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin n_errors++; $display("FAIL wd_grant: got %b exp 10", req_ready); end
        cyc();
        req_valid = 2'b00;
        cyc();
        phy_ready = 1'b0;
        #1;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
        for (int k = 0; k < TO; k++) begin
            n_checks++;
            if ({timeout, done, busy} !== 4'b0001) begin
                n_errors++;
                $display("FAIL wd_early[%0d]: got to=%b done=%b busy=%b exp 0/00/1", k, timeout, done, busy);
            end
            cyc();
            #1;
        end
        n_checks++;
        if ({timeout, done, error, busy} !== 6'b110100) begin
            n_errors++;
            $display("FAIL wd_fire: got to=%b done=%b err=%b busy=%b exp 1/10/10/0", timeout, done, error, busy);
        end
        cyc();
        #1;
        n_checks++;
        if ({timeout, done} !== 3'b000) begin n_errors++; $display("FAIL wd_pulse: got to=%b done=%b exp 0/00", timeout, done); end
`else
        for (int k = 0; k < 40; k++) begin
            n_checks++;
            if ({timeout, done, busy} !== 4'b0001) begin
                n_errors++;
                $display("FAIL nowd_wait[%0d]: got to=%b done=%b busy=%b exp 0/00/1", k, timeout, done, busy);
            end
            cyc();
            #1;
        end
        phy_done = 1'b1;
        cyc();
        phy_done = 1'b0;
        #1;
        n_checks++;
        if ({timeout, done, error} !== 5'b01000) begin
            n_errors++;
            $display("FAIL nowd_done: got to=%b done=%b err=%b exp 0/10/00", timeout, done, error);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ready_stall_error();
        test_mid_reset();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
